// File: rtl/load_align_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_align_unit
// Description : Load data path that issues one or two word-aligned reads and
//               returns the extracted bytes, sign- or zero-extended to XLEN.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align_unit #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int MISALIGN_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [1:0]        ld_size,
    input  logic              ld_unsigned,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_fault
);

    localparam int c_B     = XLEN / 8;
    localparam int c_OFF_W = $clog2(c_B);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD0  = 2'd1,
        S_RD1  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_ld_ready;
    logic                r_mem_req;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_wb_valid;
    logic [XLEN-1:0]     r_wb_data;
    logic                r_wb_fault;
    logic [c_OFF_W-1:0]  r_off;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic                r_cross;
    logic [XLEN-1:0]     r_lo;

    logic [c_OFF_W-1:0]  w_off;
    logic [4:0]          w_end;
    logic                w_cross;
    logic [2:0]          w_nmask;
    logic                w_misal;
    logic                w_illegal;
    logic                w_fault;
    logic [2*XLEN-1:0]   w_cat;
    logic [XLEN-1:0]     w_sel;
    logic [XLEN-1:0]     w_mask;
    logic                w_sgn;
    logic [XLEN-1:0]     w_ext;

    // Request decode on the incoming address/size
    assign w_off     = ld_addr[c_OFF_W-1:0];
    assign w_end     = 5'(w_off) + (5'd1 << ld_size);
    assign w_cross   = (w_end > 5'(c_B));
    assign w_misal   = ((ld_addr[2:0] & w_nmask) != 3'd0);
    assign w_illegal = (ld_size == 2'd3) && (XLEN == 32);
    assign w_fault   = w_illegal || (w_misal && (MISALIGN_EN == 0));

    always_comb begin
        w_nmask = 3'd0;
        case (ld_size)
            2'd0:    w_nmask = 3'd0;
            2'd1:    w_nmask = 3'd1;
            2'd2:    w_nmask = 3'd3;
            default: w_nmask = 3'd7;
        endcase
    end

    // In RD1 the current beat is the high word; in RD0 the high word is zero
    assign w_cat = (r_state == S_RD1) ? {mem_rdata, r_lo} : {{XLEN{1'b0}}, mem_rdata};
    assign w_sel = XLEN'(w_cat >> {r_off, 3'b000});

    always_comb begin
        w_mask = '1;
        w_sgn  = 1'b0;
        case (r_size)
            2'd0: begin
                w_mask = XLEN'(8'hFF);
                w_sgn  = w_sel[7];
            end
            2'd1: begin
                w_mask = XLEN'(16'hFFFF);
                w_sgn  = w_sel[15];
            end
            2'd2: begin
                w_mask = XLEN'(32'hFFFF_FFFF);
                w_sgn  = w_sel[31];
            end
            default: begin
                w_mask = '1;
                w_sgn  = 1'b0;
            end
        endcase
    end

    // A full-width mask leaves ~w_mask zero, so no extension happens
    assign w_ext = (w_sel & w_mask) | ((w_sgn && !r_unsigned) ? ~w_mask : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ld_ready <= 1'b1;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_wb_fault <= 1'b0;
            r_off      <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_cross    <= 1'b0;
            r_lo       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ld_valid) begin
                        r_off      <= w_off;
                        r_size     <= ld_size;
                        r_unsigned <= ld_unsigned;
                        r_cross    <= w_cross;
                        r_ld_ready <= 1'b0;
                        if (w_fault) begin
                            r_state    <= S_RESP;
                            r_wb_valid <= 1'b1;
                            r_wb_fault <= 1'b1;
                            r_wb_data  <= '0;
                        end else begin
                            r_state    <= S_RD0;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= {ld_addr[ADDR_W-1:c_OFF_W], {c_OFF_W{1'b0}}};
                        end
                    end
                end
                S_RD0: begin
                    if (mem_rvalid) begin
                        r_lo <= mem_rdata;
                        if (r_cross) begin
                            r_state    <= S_RD1;
                            r_mem_addr <= r_mem_addr + ADDR_W'(c_B);
                        end else begin
                            r_state    <= S_RESP;
                            r_mem_req  <= 1'b0;
                            r_wb_valid <= 1'b1;
                            r_wb_fault <= 1'b0;
                            r_wb_data  <= w_ext;
                        end
                    end
                end
                S_RD1: begin
                    if (mem_rvalid) begin
                        r_state    <= S_RESP;
                        r_mem_req  <= 1'b0;
                        r_wb_valid <= 1'b1;
                        r_wb_fault <= 1'b0;
                        r_wb_data  <= w_ext;
                    end
                end
                default: begin
                    if (wb_ready) begin
                        r_state    <= S_IDLE;
                        r_wb_valid <= 1'b0;
                        r_ld_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign ld_ready = r_ld_ready;
    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign wb_valid = r_wb_valid;
    assign wb_data  = r_wb_data;
    assign wb_fault = r_wb_fault;

endmodule
`default_nettype wire

// File: tb/tb_load_align_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_align_unit
// Description : Directed self-checking bench for load_align_unit (XLEN=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_align_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid, ld_ready, ld_unsigned;
    logic [31:0] ld_addr;
    logic [1:0]  ld_size;
    logic        mem_req, mem_rvalid;
    logic [31:0] mem_addr, mem_rdata;
    logic        wb_valid, wb_ready, wb_fault;
    logic [31:0] wb_data;

    logic        ld_valid2, ld_ready2;
    logic [31:0] ld_addr2;
    logic [1:0]  ld_size2;
    logic        mem_req2, mem_rvalid2;
    logic [31:0] mem_addr2, mem_rdata2;
    logic        wb_valid2, wb_fault2;
    logic [31:0] wb_data2;

    logic        auto_mode;
    logic        man_rvalid;
    int          nvec = 0;
    int          nerr = 0;
    int          rd_cnt = 0;
    logic [31:0] rd_addr [0:63];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h8899_AABB;
            32'h0000_0104: return 32'h1122_3344;
            32'hFFFF_FFFC: return 32'hDEAD_BEEF;
            32'h0000_0000: return 32'h0102_0304;
            default:       return 32'h0;
        endcase
    endfunction

    assign mem_rvalid  = auto_mode ? mem_req : man_rvalid;
    assign mem_rdata   = mem_word(mem_addr);
    assign mem_rvalid2 = mem_req2;
    assign mem_rdata2  = mem_word(mem_addr2);

    always @(posedge clk) begin
        if (!rst && mem_req && mem_rvalid) begin
            rd_addr[rd_cnt % 64] <= mem_addr;
            rd_cnt <= rd_cnt + 1;
        end
    end

    load_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_size(ld_size), .ld_unsigned(ld_unsigned),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_fault(wb_fault)
    );

    load_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(0)) dut_nomis (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid2), .ld_ready(ld_ready2), .ld_addr(ld_addr2),
        .ld_size(ld_size2), .ld_unsigned(1'b0),
        .mem_req(mem_req2), .mem_addr(mem_addr2),
        .mem_rvalid(mem_rvalid2), .mem_rdata(mem_rdata2),
        .wb_valid(wb_valid2), .wb_ready(1'b1),
        .wb_data(wb_data2), .wb_fault(wb_fault2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one load on the main instance; caller is 1 time unit after an edge
    task automatic run_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                            input logic u, input logic [31:0] exp_data, input logic exp_fault,
                            input int exp_lat, input int exp_reads,
                            input logic [31:0] exp_a0, input logic [31:0] exp_a1);
        int start;
        int lat;
        start = rd_cnt;
        chk({tag, "_ready"}, ld_ready, 1'b1);
        ld_valid = 1'b1; ld_addr = a; ld_size = sz; ld_unsigned = u;
        tick();
        ld_valid = 1'b0;
        lat = 1;
        while (!wb_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_data"}, wb_data, exp_data);
        chk({tag, "_fault"}, wb_fault, exp_fault);
        chk({tag, "_reads"}, rd_cnt - start, exp_reads);
        if (exp_reads > 0) chk({tag, "_addr0"}, rd_addr[start % 64], exp_a0);
        if (exp_reads > 1) chk({tag, "_addr1"}, rd_addr[(start + 1) % 64], exp_a1);
        tick();
        chk({tag, "_idle"}, {wb_valid, ld_ready}, 2'b01);
    endtask

    initial begin
        rst = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_size = '0; ld_unsigned = 1'b0;
        wb_ready = 1'b1; auto_mode = 1'b1; man_rvalid = 1'b0;
        ld_valid2 = 1'b0; ld_addr2 = '0; ld_size2 = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_ready", ld_ready, 1'b1);
        chk("rst_memreq", mem_req, 1'b0);
        chk("rst_memaddr", mem_addr, 32'h0);
        chk("rst_wbvalid", wb_valid, 1'b0);
        chk("rst_wbdata", wb_data, 32'h0);
        chk("rst_wbfault", wb_fault, 1'b0);

        run_load("lb_103",  32'h103, 2'd0, 1'b0, 32'hFFFF_FF88, 1'b0, 2, 1, 32'h100, 32'h0);
        run_load("lhu_102", 32'h102, 2'd1, 1'b1, 32'h0000_8899, 1'b0, 2, 1, 32'h100, 32'h0);
        run_load("lw_102",  32'h102, 2'd2, 1'b0, 32'h3344_8899, 1'b0, 3, 2, 32'h100, 32'h104);
        run_load("lh_103",  32'h103, 2'd1, 1'b0, 32'h0000_4488, 1'b0, 3, 2, 32'h100, 32'h104);
        run_load("lbu_101", 32'h101, 2'd0, 1'b1, 32'h0000_00AA, 1'b0, 2, 1, 32'h100, 32'h0);
        run_load("lw_100",  32'h100, 2'd2, 1'b0, 32'h8899_AABB, 1'b0, 2, 1, 32'h100, 32'h0);
        run_load("ld_ill",  32'h100, 2'd3, 1'b0, 32'h0,         1'b1, 1, 0, 32'h0,   32'h0);
        run_load("lw_wrap", 32'hFFFF_FFFE, 2'd2, 1'b0, 32'h0304_DEAD, 1'b0, 3, 2,
                 32'hFFFF_FFFC, 32'h0);

        // Misaligned load on the instance with splitting disabled
        ld_valid2 = 1'b1; ld_addr2 = 32'h102; ld_size2 = 2'd2;
        tick();
        ld_valid2 = 1'b0;
        chk("nomis_valid", wb_valid2, 1'b1);
        chk("nomis_fault", wb_fault2, 1'b1);
        chk("nomis_data", wb_data2, 32'h0);
        chk("nomis_memreq", mem_req2, 1'b0);
        tick();
        chk("nomis_ready", ld_ready2, 1'b1);
        ld_valid2 = 1'b1; ld_addr2 = 32'h104; ld_size2 = 2'd2;
        tick();
        ld_valid2 = 1'b0;
        chk("nomis_al_req", mem_req2, 1'b1);
        tick();
        chk("nomis_al_valid", wb_valid2, 1'b1);
        chk("nomis_al_data", {wb_fault2, wb_data2}, {1'b0, 32'h1122_3344});
        tick();

        // Write-back back-pressure
        wb_ready = 1'b0;
        ld_valid = 1'b1; ld_addr = 32'h104; ld_size = 2'd1; ld_unsigned = 1'b0;
        tick();
        ld_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("hold_state", {wb_valid, ld_ready, wb_data}, {1'b1, 1'b0, 32'h0000_3344});
            ld_valid = 1'b1; ld_addr = 32'h100; ld_size = 2'd2;
            tick();
        end
        ld_valid = 1'b0;
        wb_ready = 1'b1;
        chk("hold_last", {wb_valid, wb_data}, {1'b1, 32'h0000_3344});
        tick();
        chk("hold_release", {wb_valid, ld_ready}, 2'b01);

        // Slow memory: response withheld for three cycles
        auto_mode = 1'b0;
        ld_valid = 1'b1; ld_addr = 32'h101; ld_size = 2'd0; ld_unsigned = 1'b1;
        tick();
        ld_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("slow_req", {mem_req, wb_valid}, 2'b10);
            tick();
        end
        man_rvalid = 1'b1;
        tick();
        man_rvalid = 1'b0;
        chk("slow_resp", {wb_valid, mem_req, wb_data}, {1'b1, 1'b0, 32'h0000_00AA});
        tick();

        // Reset while the second read of a crossing load is outstanding
        ld_valid = 1'b1; ld_addr = 32'h102; ld_size = 2'd2; ld_unsigned = 1'b0;
        tick();
        ld_valid = 1'b0;
        man_rvalid = 1'b1;
        tick();
        man_rvalid = 1'b0;
        chk("rd1_addr", {mem_req, mem_addr}, {1'b1, 32'h104});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_rd1", {mem_req, ld_ready, wb_valid}, 3'b010);
        man_rvalid = 1'b1;
        tick();
        man_rvalid = 1'b0;
        chk("late_rvalid", {mem_req, ld_ready, wb_valid}, 3'b010);
        auto_mode = 1'b1;
        run_load("lw_104", 32'h104, 2'd2, 1'b0, 32'h1122_3344, 1'b0, 2, 1, 32'h104, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Multi-cycle load data path between the data memory port and the register-file write-back mux.
- Issues word-aligned memory reads for a byte, half, word or dword load. A load that straddles a memory word takes two reads.
- Extracts the addressed bytes (little-endian), then sign- or zero-extends them to XLEN.
- Parametrised in data width and misalignment mode. Valid/ready on the load side, req/rvalid on the memory side.

Parameters:
- XLEN, 32, datapath and memory word width; legal values 32 or 64.
- ADDR_W, 32, byte address width.
- MISALIGN_EN, 1, 1 = split misaligned loads into two reads; 0 = raise wb_fault instead.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- ld_valid, input, 1, load request valid.
- ld_ready, output, 1, unit can accept a request; high only in IDLE.
- ld_addr, input, ADDR_W, byte address.
- ld_size, input, 2, 0 = byte, 1 = half, 2 = word, 3 = dword.
- ld_unsigned, input, 1, 1 = zero-extend, 0 = sign-extend.
- mem_req, output, 1, memory read request; held until mem_rvalid.
- mem_addr, output, ADDR_W, word-aligned read address; low log2(XLEN/8) bits are always 0.
- mem_rvalid, input, 1, read data valid; completes the outstanding mem_req.
- mem_rdata, input, XLEN, read data.
- wb_valid, output, 1, result available.
- wb_ready, input, 1, write-back consumes result.
- wb_data, output, XLEN, extended load result.
- wb_fault, output, 1, misaligned (MISALIGN_EN=0) or illegal size; qualified by wb_valid.

Behaviour:
- Clock and reset: one clock domain, clk; rst is synchronous and active-high.
- Reset values: state=IDLE; ld_ready=1; mem_req=0; mem_addr=0; wb_valid=0; wb_data=0; wb_fault=0; all captured data cleared.
- Definitions:
  - B = XLEN/8; off = ld_addr mod B; n = 1 << ld_size.
  - cross = (off + n > B).
  - misal = (ld_addr mod n != 0).
  - illegal = (ld_size==3 && XLEN==32).
- Accept: ld_valid && ld_ready at rising edge. addr, size and unsigned are registered at that edge.
- FSM states:
  - IDLE: on accept, go to RESP with wb_fault=1 and wb_data=0 (no mem_req) if illegal, or if misal && !MISALIGN_EN. Otherwise go to RD0 with mem_addr = addr & ~(B-1).
  - RD0: mem_req=1. On mem_rvalid, capture lo=mem_rdata. If cross, go to RD1 with mem_addr += B; otherwise go to RESP.
  - RD1: mem_req=1. On mem_rvalid, capture hi=mem_rdata and go to RESP.
  - RESP: wb_valid=1; wb_data and wb_fault are stable. On wb_ready, go to IDLE.
- mem_rvalid may arrive in the same cycle mem_req rises. mem_req deasserts the cycle after mem_rvalid. Exactly one read is outstanding at a time.
- Latency with zero-wait memory and wb_ready=1:
  - aligned or non-crossing load: accept at T, mem_req at T+1, wb_valid at T+2, ld_ready at T+3;
  - crossing load: wb_valid at T+3;
  - fault: wb_valid at T+1.
- Extraction: shifted = {hi, lo} >> (8*off), with hi=0 when not crossing. Take the low 8*n bits. Sign-extend from bit 8*n-1 unless unsigned. For n == B (full-width load), no extension.
- Boundaries:
  - mem_rvalid outside RD0/RD1 is ignored, including a late response after reset.
  - ld_valid outside IDLE is ignored; ld_ready=0 there.
  - A load ending exactly at a word boundary does not cross.
  - The second read address wraps modulo 2^ADDR_W.
  - rst in any state returns to IDLE the next cycle: mem_req=0, wb_valid=0, the pending load is discarded.
  - wb_ready low in RESP holds wb_valid and wb_data unchanged indefinitely.

Test Plan:
- Setup: XLEN=32, MISALIGN_EN=1 unless stated. mem[0x100]=0x8899AABB, mem[0x104]=0x11223344.
- LB signed at 0x103 -> single read at 0x100; wb_data=0xFFFFFF88; wb_valid at T+2.
- LHU at 0x102 -> single read at 0x100; wb_data=0x00008899.
- LW at 0x102 -> reads at 0x100 then 0x104; wb_data=0x33448899; wb_valid at T+3. LH signed at 0x103 -> wb_data=0x00004488.
- MISALIGN_EN=0, LW at 0x102 -> no mem_req; wb_valid at T+1 with wb_fault=1 and wb_data=0. LD (size 3) with XLEN=32 -> wb_fault=1.
- wb_ready=0 for 5 cycles in RESP -> wb_valid and wb_data stable, ld_ready=0. Then a 3-cycle mem_rvalid delay -> mem_req held high for all 3 cycles.
- rst asserted during RD1 -> next cycle mem_req=0, ld_ready=1. A late mem_rvalid is ignored; a following LW at 0x104 returns 0x11223344.
